// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_MAX_WAIT = 15;

  // Counter width able to hold 0..max_wait; never narrower than one bit.
  function automatic int wait_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

  localparam int WAIT_W = wait_width(DEF_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Clear/enable up-counter measuring how long a memory request has been open.
module fetch_wait_timer #(
  parameter int CNT_W   = 4,
  parameter int MAX_CNT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_q;

  // Count request cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!reset)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: req/ack read of instruction memory into a single-entry IR.
//
// state | meaning
// IDLE  | no request open; may start a fetch when the IR is free
// REQ   | mem_req high, waiting for mem_ack (bounded by MAX_WAIT)
// ERR   | memory timed out; absorbing until reset
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               fetch_en,
  input  logic               flush,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               pc_inc,
  output logic               fetch_err
);

  localparam int CNT_W = wait_width(MAX_WAIT);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic [INSTR_W-1:0] ir_out_q, ir_out_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               pc_inc_q, pc_inc_d;
  logic               fetch_err_q, fetch_err_d;
  logic               discard_q, discard_d;

  logic               tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0]   wait_cnt;

  fetch_wait_timer #(
    .CNT_W   (CNT_W),
    .MAX_CNT (MAX_WAIT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cnt_o (wait_cnt),
    .tc_o  (tmr_tc)
  );

  // State and output registers; reset clears everything, even mid-request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      ir_out_q    <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      pc_inc_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      ir_out_q    <= ir_out_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      pc_inc_q    <= pc_inc_d;
      fetch_err_q <= fetch_err_d;
      discard_q   <= discard_d;
    end
  end

  // Next-state: fetch start, ack/timeout handling, IR consume and flush.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    ir_out_d    = ir_out_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    pc_inc_d    = 1'b0;
    fetch_err_d = fetch_err_q;
    discard_d   = discard_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
        if (fetch_en && !flush && (!ir_valid_q || ir_ready)) begin
          mem_addr_d = pc_in;
          mem_req_d  = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = REQ;
        end
        if (flush) ir_valid_d = 1'b0;
      end
      REQ: begin
        if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!discard_q && !flush) begin
            ir_out_d   = mem_rdata;
            ir_pc_d    = mem_addr_q;
            ir_valid_d = 1'b1;
            pc_inc_d   = 1'b1;
          end else begin
            discard_d = 1'b0;
          end
        end else begin
          if (tmr_tc) begin
            mem_req_d   = 1'b0;
            fetch_err_d = 1'b1;
            state_d     = ERR;
          end else begin
            tmr_en = 1'b1;
          end
          // The response to this request is still owed; mark it for drop.
          if (flush) discard_d = 1'b1;
        end
        if (flush) ir_valid_d = 1'b0;
      end
      ERR: begin
        mem_req_d   = 1'b0;
        fetch_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_req   = mem_req_q;
  assign ir_out    = ir_out_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign pc_inc    = pc_inc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed test-plan steps plus a
// randomized phase checked against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc_in;
  logic        fetch_en;
  logic        flush;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_inc;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;
  int inc_cnt = 0;
  int consec_viol = 0;
  logic prev_inc = 1'b0;

  instr_fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc_inc    (pc_inc),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; track pc_inc pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pc_inc) inc_cnt++;
    if (pc_inc && prev_inc) consec_viol++;
    prev_inc = pc_inc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(mem_req),   0);
    chk({tag, "_addr"},  32'(mem_addr),  0);
    chk({tag, "_ir"},    32'(ir_out),    0);
    chk({tag, "_irpc"},  32'(ir_pc),     0);
    chk({tag, "_valid"}, 32'(ir_valid),  0);
    chk({tag, "_inc"},   32'(pc_inc),    0);
    chk({tag, "_err"},   32'(fetch_err), 0);
  endtask

  // Zero-wait fetch with the IR free or draining: start edge, then ack edge.
  task automatic fast_fetch(input logic [7:0] pc, input logic [15:0] d);
    pc_in = pc; fetch_en = 1'b1; mem_ack = 1'b1; mem_rdata = d;
    tick();
    chk("ff_req", 32'(mem_req), 1);
    chk("ff_addr", 32'(mem_addr), 32'(pc));
    tick();
    chk("ff_valid", 32'(ir_valid), 1);
    chk("ff_irpc", 32'(ir_pc), 32'(pc));
    chk("ff_ir", 32'(ir_out), 32'(d));
    chk("ff_inc", 32'(pc_inc), 1);
  endtask

  initial begin
    int base, cycles, lat, fcyc, dly;
    logic do_flush, expect_cap;
    logic [7:0] rpc;
    logic [15:0] rdat;

    reset = 1'b0; pc_in = 8'h7C; fetch_en = 1'b1; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;

    // Reset and basic zero-wait fetch.
    tick(); tick();
    chk_all_zero("rst");
    reset = 1'b1;
    tick();
    chk("basic_req", 32'(mem_req), 1);
    chk("basic_addr", 32'(mem_addr), 32'h7C);
    chk("basic_noinc", 32'(pc_inc), 0);
    mem_ack = 1'b1; mem_rdata = 16'hA55A;
    tick();
    chk("basic_ir", 32'(ir_out), 32'hA55A);
    chk("basic_irpc", 32'(ir_pc), 32'h7C);
    chk("basic_valid", 32'(ir_valid), 1);
    chk("basic_inc", 32'(pc_inc), 1);
    chk("basic_reqdrop", 32'(mem_req), 0);
    mem_ack = 1'b0;
    tick();
    chk("basic_inc_once", 32'(pc_inc), 0);
    chk("bp_noreq1", 32'(mem_req), 0);
    tick();
    chk("bp_noreq2", 32'(mem_req), 0);
    chk("bp_hold", 32'(ir_valid), 1);

    // Streaming with ir_ready held: one instruction every 2 cycles.
    ir_ready = 1'b1;
    base = inc_cnt;
    fast_fetch(8'h7C, 16'h1111);
    fast_fetch(8'h7D, 16'h2222);
    fast_fetch(8'h7E, 16'h3333);
    chk("stream_inc3", 32'(inc_cnt - base), 3);

    // Wrap-around addresses are passed through unchanged.
    fast_fetch(8'hFF, 16'h4444);
    fast_fetch(8'h00, 16'h5555);
    fetch_en = 1'b0; mem_ack = 1'b0;
    tick();
    chk("drain_valid", 32'(ir_valid), 0);

    // Flush during an outstanding request with delayed ack.
    base = inc_cnt;
    pc_in = 8'h30; fetch_en = 1'b1;
    tick();
    chk("fl_req1", 32'(mem_req), 1);
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    chk("fl_req2", 32'(mem_req), 1);
    flush = 1'b0;
    tick();
    chk("fl_req3", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    chk("fl_reqdrop", 32'(mem_req), 0);
    chk("fl_novalid", 32'(ir_valid), 0);
    mem_ack = 1'b0;
    tick();
    chk("fl_noinc", 32'(inc_cnt - base), 0);
    fast_fetch(8'h31, 16'h1234);
    fetch_en = 1'b0; mem_ack = 1'b0;
    tick();

    // Ack on the 16th request cycle is still accepted.
    ir_ready = 1'b0;
    pc_in = 8'h40; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    cycles = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_req) cycles++;
    end
    chk("late_reqcycles", 32'(cycles), 16);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    chk("late_err", 32'(fetch_err), 0);
    chk("late_valid", 32'(ir_valid), 1);
    chk("late_ir", 32'(ir_out), 32'hBEEF);
    mem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;

    // Randomized transactions against a per-fetch model: latency, optional
    // flush within the request window, and consume delay are all random.
    for (int t = 0; t < 24; t++) begin
      rpc = 8'($urandom); rdat = 16'($urandom);
      lat = $urandom_range(0, 6);
      do_flush = ($urandom_range(0, 3) == 0);
      fcyc = $urandom_range(0, lat);
      expect_cap = !do_flush;
      base = inc_cnt;
      pc_in = rpc; fetch_en = 1'b1;
      tick();
      chk("rnd_req", 32'(mem_req), 1);
      chk("rnd_addr", 32'(mem_addr), 32'(rpc));
      fetch_en = 1'b0;
      for (int c = 0; c <= lat; c++) begin
        mem_ack = (c == lat);
        mem_rdata = (c == lat) ? rdat : 16'($urandom);
        flush = do_flush && (c == fcyc);
        tick();
        if (c < lat) chk("rnd_hold", 32'(mem_req), 1);
      end
      mem_ack = 1'b0; flush = 1'b0;
      chk("rnd_reqdrop", 32'(mem_req), 0);
      chk("rnd_valid", 32'(ir_valid), 32'(expect_cap));
      chk("rnd_inc", 32'(inc_cnt - base), 32'(expect_cap));
      if (expect_cap) begin
        chk("rnd_ir", 32'(ir_out), 32'(rdat));
        chk("rnd_irpc", 32'(ir_pc), 32'(rpc));
      end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) tick();
      chk("rnd_stay", 32'(ir_valid), 32'(expect_cap));
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      chk("rnd_consumed", 32'(ir_valid), 0);
    end

    // Timeout: ack never comes.
    pc_in = 8'h50; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    cycles = mem_req ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req) cycles++;
      else break;
    end
    chk("to_reqcycles", 32'(cycles), 16);
    chk("to_err", 32'(fetch_err), 1);
    chk("to_reqlow", 32'(mem_req), 0);
    flush = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;
    tick(); tick(); tick();
    chk("to_sticky", 32'(fetch_err), 1);
    chk("to_noreq", 32'(mem_req), 0);
    flush = 1'b0; fetch_en = 1'b0; ir_ready = 1'b0;

    // Reset clears the error; then reset mid-request with a same-edge ack.
    reset = 1'b0;
    tick();
    chk("rst_clr_err", 32'(fetch_err), 0);
    reset = 1'b1;
    pc_in = 8'h60; fetch_en = 1'b1;
    tick();
    chk("mid_req", 32'(mem_req), 1);
    fetch_en = 1'b0;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    chk_all_zero("mid_rst");
    reset = 1'b1; mem_ack = 1'b0;
    tick();
    chk_all_zero("mid_after");

    chk("inc_not_consecutive", 32'(consec_viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Downstream neighbour of the 8-bit program counter: takes PCout as fetch address, runs a req/ack read on instruction memory, and holds the returned word in a single-entry instruction register for the decode stage.
- Pulses pc_inc to advance the PC after each accepted fetch.
- Supports flush on a taken branch, and a bounded-wait timeout that flags a hung memory.

Parameters:
- ADDR_W, 8, fetch address width; matches the PC width.
- INSTR_W, 16, instruction word width.
- MAX_WAIT, 15, last cycle count in REQ on which mem_ack is still accepted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_in  in  ADDR_W  current PC value (PCout).
- fetch_en  in  1  allows new fetches to start.
- flush  in  1  branch taken; discard the buffered and in-flight instruction.
- mem_addr  out  ADDR_W  memory read address.
- mem_req  out  1  read request.
- mem_ack  in  1  memory has mem_rdata valid this cycle.
- mem_rdata  in  INSTR_W  instruction word.
- ir_out  out  INSTR_W  instruction register.
- ir_pc  out  ADDR_W  address ir_out was fetched from.
- ir_valid  out  1  ir_out holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir_out this cycle.
- pc_inc  out  1  one-cycle pulse: PC must increment.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, wait_cnt=0, discard=0, every output 0. Reset overrides everything, including mid-request.
- IDLE: if fetch_en && !flush && (!ir_valid || ir_ready), then next edge: mem_addr<=pc_in, mem_req<=1, wait_cnt<=0, go to REQ. Otherwise stay in IDLE.
- REQ: mem_req stays 1 and mem_addr stays stable until mem_ack is sampled high. mem_req is never dropped early, even on flush.
- REQ on an edge with mem_ack=1:
  - mem_req<=0, go to IDLE.
  - If !discard && !flush: ir_out<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1, pc_inc<=1 for exactly one cycle.
  - Else: data dropped, no pc_inc, discard<=0.
- REQ on an edge with mem_ack=0: if wait_cnt==MAX_WAIT, go to ERR with mem_req<=0, fetch_err<=1. Otherwise wait_cnt<=wait_cnt+1.
  - An ack on the cycle where wait_cnt==MAX_WAIT is accepted.
  - mem_req is therefore high for at most MAX_WAIT+1 cycles.
- ERR: absorbing state. mem_req=0, fetch_err=1, ir_valid unchanged. Leaves only on reset.
- Consume: ir_valid && ir_ready at an edge clears ir_valid, unless a new capture happens on the same edge.
  - Only one request is ever outstanding, so the buffer is empty when the ack arrives; no overwrite is possible.
- Flush (any state except ERR): ir_valid<=0 at the edge. Flush has priority over ir_ready and over capture.
  - In REQ: discard<=1 so the pending response is dropped.
  - In IDLE: blocks a fetch start that cycle.
- mem_ack outside REQ is ignored.
- Latency and throughput:
  - pc_in sampled at edge N; mem_req high in cycle N+1.
  - With a zero-wait ack, ir_valid and pc_inc are high in cycle N+2.
  - Peak throughput: one instruction per 2 cycles.
- pc_inc is never high in two consecutive cycles.
- Address width: mem_addr is a plain copy of pc_in with no arithmetic; PC wrap (8'hFF to 8'h00) is handled entirely by the program counter.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, REQ, ERR}, 2 bits.
  - default ADDR_W and INSTR_W.
  - WAIT_W = $clog2(MAX_WAIT+1).
- One sub-module, fetch_wait_timer: clear/enable counter with a terminal-count output (wait_cnt==MAX_WAIT), instantiated once.
- FSM, instruction register and discard flag stay in instr_fetch_unit.

Test Plan:
- Reset and basic fetch, zero-wait memory:
  - Stimulus: reset low for 2 edges, then high; pc_in=8'h7C; fetch_en=1; ack with 16'hA55A in the first request cycle; ir_ready=0.
  - Response: all outputs 0 during reset; mem_req=1 with mem_addr=8'h7C one cycle after the start edge; next cycle ir_out=16'hA55A, ir_pc=8'h7C, ir_valid=1, single pc_inc pulse; no new mem_req while ir_valid=1 and ir_ready=0.
- Back-pressure and streaming:
  - Stimulus: ir_ready held 1; memory acks immediately; pc_in steps 8'h7C, 8'h7D, 8'h7E.
  - Response: ir_pc sequence 7C, 7D, 7E, one instruction every 2 cycles; exactly three pc_inc pulses.
- Wrap-around addresses:
  - Stimulus: pc_in=8'hFF, then 8'h00.
  - Response: mem_addr=8'hFF, then 8'h00; ir_pc matches each.
- Flush during an outstanding request:
  - Stimulus: memory delays ack by 3 cycles; flush=1 in the second REQ cycle.
  - Response: mem_req held until the ack; the returned data is not loaded; ir_valid stays 0; no pc_inc; the next fetch uses the new pc_in.
- Timeout:
  - Stimulus: MAX_WAIT=15, mem_ack never asserted.
  - Response: mem_req high for exactly 16 cycles, then fetch_err=1 and mem_req=0, sticky until reset. Separate run: ack in the 16th cycle is accepted, fetch_err stays 0.
- Reset mid-request:
  - Stimulus: reset=0 while in REQ; ack arrives on the same edge.
  - Response: ack ignored; state IDLE; all outputs 0 in the following cycle.
